// File: rtl/axi_rd_slave_if.sv
// axi_rd_slave_if: AXI4 read address and read data channel bundle.
interface axi_rd_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [1:0]        arburst;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;
  modport master (
    output araddr, arvalid, arburst, arlen, arsize, rready,
    input  arready, rdata, rresp, rvalid, rlast
  );
  modport slave (
    input  araddr, arvalid, arburst, arlen, arsize, rready,
    output arready, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_rd_slave.sv
// axi_rd_slave: AXI4 read responder serving single/burst reads from a 64-bit synchronous memory.
module axi_rd_slave #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_slave_if.slave     bus,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, CAP, RESP} state_t;
  localparam logic [ADDR_W:0] MEM_END = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] step, wrap_mask, adv_addr, req_addr;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              berr_q, berr_d, aerr_q, aerr_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d, mem_ren_q, mem_ren_d;
  logic              accept, advance, go_req, ar_err, req_berr, req_out, r_hs;
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a < MEM_BASE) || ({1'b0, a} >= MEM_END);
  endfunction
  always_comb begin
    accept    = (state_q == IDLE) && bus.arvalid;
    r_hs      = (state_q == RESP) && bus.rready;
    advance   = r_hs && !rlast_q;
    go_req    = accept || advance;
    ar_err    = (bus.arsize > 3'd3) || (bus.arburst == 2'b11) ||
                ((bus.arburst == 2'b10) && !(bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    // WRAP keeps the upper bits and rolls the offset within the (len+1)*step window
    adv_addr  = (burst_q == 2'b00) ? addr_q :
                (burst_q == 2'b10) ? ((addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask)) :
                addr_q + step;
    req_addr  = accept ? bus.araddr : adv_addr;
    req_berr  = accept ? ar_err : berr_q;
    req_out   = out_of_range(req_addr);
    state_d    = go_req ? REQ :
                 (state_q == REQ) ? CAP :
                 (state_q == CAP) ? RESP :
                 (r_hs && rlast_q) ? IDLE : state_q;
    addr_d     = go_req ? req_addr : addr_q;
    len_d      = accept ? bus.arlen : len_q;
    size_d     = accept ? bus.arsize : size_q;
    burst_d    = accept ? bus.arburst : burst_q;
    berr_d     = req_berr;
    aerr_d     = go_req ? req_out : aerr_q;
    cnt_d      = accept ? 8'd0 : advance ? cnt_q + 8'd1 : cnt_q;
    mem_ren_d  = go_req && !req_berr && !req_out;
    mem_addr_d = go_req ? {req_addr[ADDR_W-1:3], 3'b000} : mem_addr_q;
    rdata_d    = (state_q == CAP) ? ((berr_q || aerr_q) ? '0 : mem_rdata) : rdata_q;
    rresp_d    = (state_q == CAP) ? (berr_q ? 2'b10 : aerr_q ? 2'b11 : 2'b00) : rresp_q;
    rvalid_d   = (state_q == CAP) ? 1'b1 : r_hs ? 1'b0 : rvalid_q;
    rlast_d    = (state_q == CAP) ? (cnt_q == len_q) : r_hs ? 1'b0 : rlast_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      berr_q     <= 1'b0;
      aerr_q     <= 1'b0;
      cnt_q      <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      berr_q     <= berr_d;
      aerr_q     <= aerr_d;
      cnt_q      <= cnt_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
    end
  end
  assign bus.arready = (state_q == IDLE);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign mem_ren     = mem_ren_q;
  assign mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_axi_rd_slave.sv
// tb_axi_rd_slave: scoreboard bench for axi_rd_slave with a behavioural memory.
module tb_axi_rd_slave;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0800_0000;
  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  int          total = 0, bad = 0, cyc = 0, evt_cyc = 0, beats = 0;
  logic        rvalid_prev = 1'b0, last_done = 1'b0;
  beat_t       exp_q[$];
  logic [31:0] mem_q[$];
  axi_rd_slave_if bus ();
  axi_rd_slave dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return (a == MEM_BASE) ? 64'h1122_3344_5566_7788 : {a ^ 32'h5a5a_0f0f, ~a};
  endfunction
  always @(posedge clk) mem_rdata <= mem_ren ? mem_word(mem_addr) : 64'hbad0_bad0_bad0_bad0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      rvalid_prev = 1'b0;
      last_done   = 1'b0;
    end else begin
      if (last_done) check("arready_after_last", 64'(bus.arready), 64'd1);
      last_done = 1'b0;
      if (mem_ren) begin
        check("ren_lat", 64'(cyc - evt_cyc), 64'd1);
        if (mem_q.size() == 0) check("ren_unexpected", 64'd1, 64'd0);
        else check("mem_addr", 64'(mem_addr), 64'(mem_q.pop_front()));
      end
      if (bus.rvalid) begin
        if (exp_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else begin
          check("rdata", bus.rdata, exp_q[0].data);
          check("rresp", 64'(bus.rresp), 64'(exp_q[0].resp));
          check("rlast", 64'(bus.rlast), 64'(exp_q[0].last));
          if (!rvalid_prev) check("r_lat", 64'(cyc - evt_cyc), 64'd3);
          if (bus.rready) begin
            last_done = exp_q[0].last;
            void'(exp_q.pop_front());
            beats++;
            evt_cyc = cyc;
          end
        end
      end
      if (bus.arvalid && bus.arready) evt_cyc = cyc;
      rvalid_prev = bus.rvalid && !bus.rready;
    end
  end
  task automatic issue(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, step, bsz, base;
    logic        berr, inr;
    beat_t       e;
    int          n;
    a    = addr;
    berr = (size > 3'd3) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    step = 32'd1 << size;
    for (int i = 0; i <= int'(len); i++) begin
      inr    = (a >= MEM_BASE) && (a <= MEM_BASE + MEM_SIZE - 32'd1);
      e.data = (berr || !inr) ? 64'd0 : mem_word({a[31:3], 3'b000});
      e.resp = berr ? 2'b10 : inr ? 2'b00 : 2'b11;
      e.last = (i == int'(len));
      exp_q.push_back(e);
      if (!berr && inr) mem_q.push_back({a[31:3], 3'b000});
      if (burst == 2'b01) a = a + step;
      else if (burst == 2'b10) begin
        bsz  = (32'(len) + 32'd1) * step;
        base = a - (a % bsz);
        a    = base + ((a - base + step) % bsz);
      end
    end
    beats       = 0;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ar_accept", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask
  task automatic drain(input int stall_beat);
    int left = 2;
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.rvalid && beats == stall_beat && left > 0) begin
        bus.rready = 1'b0;
        left--;
      end else bus.rready = 1'b1;
    end
    check("burst_timeout", 64'(n < 200), 64'd1);
    check("mem_left", 64'(mem_q.size()), 64'd0);
    exp_q.delete();
    mem_q.delete();
    @(posedge clk); #1;
  endtask
  task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input int stall_beat);
    issue(addr, len, size, burst);
    drain(stall_beat);
  endtask
  initial begin
    int n;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.arburst = 2'b01;
    bus.arlen   = '0;
    bus.arsize  = '0;
    bus.rready  = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_arready", 64'(bus.arready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b1;
    rd(32'h8000_0004, 8'd0, 3'd2, 2'b01, -1);
    rd(32'h8000_0000, 8'd3, 3'd3, 2'b01, 1);
    rd(32'h8000_0010, 8'd3, 3'd3, 2'b10, -1);
    rd(32'h8000_0020, 8'd2, 3'd3, 2'b00, -1);
    rd(32'h8000_0000, 8'd1, 3'd4, 2'b01, -1);
    rd(32'h8000_0000, 8'd2, 3'd3, 2'b10, -1);
    rd(32'h8000_0040, 8'd1, 3'd3, 2'b11, -1);
    rd(32'h8800_0000, 8'd0, 3'd3, 2'b01, -1);
    rd(32'h87ff_fff8, 8'd1, 3'd3, 2'b01, -1);
    rd(32'h8000_0200, 8'd7, 3'd2, 2'b10, 3);
    issue(32'h8000_0100, 8'd3, 3'd3, 2'b01);
    n = 0;
    while (!(bus.rvalid && beats == 1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_beat1", 64'(n < 50), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_rvalid", 64'(bus.rvalid), 64'd0);
    check("abort_rlast", 64'(bus.rlast), 64'd0);
    exp_q.delete();
    mem_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_arready", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    rd(32'h8000_0008, 8'd0, 3'd3, 2'b01, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
